fact_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for the calculator's factorial operation. Replaces the

---
 rtl/fact_seq_ctrl.sv | 110 +++++++++++
 tb/tb_fact_seq_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fact_seq_ctrl.sv
// Multi-cycle factorial sequencer: range-checks the operand, then does one acc*=k per clock.
// Results above the display limit are flagged as an overflow and shown as all-ones.
module fact_seq_ctrl #(
    parameter int W          = 28,
    parameter int N_MAX      = 11,
    parameter int MAX_RESULT = 99_999_999
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    input  logic [W-1:0] n,
    input  logic         cancel,
    output logic         busy,
    output logic         valid_out,
    output logic         ovrflow,
    output logic [W-1:0] d_out
);

    typedef enum logic [1:0] {IDLE, CHECK, MUL, DONE} state_t;

    localparam logic signed [W-1:0] N_MAX_S = W'(N_MAX);
    localparam logic [2*W-1:0]      MAX_P   = (2*W)'(MAX_RESULT);

    state_t         state;
    logic [W-1:0]   n_reg, acc, cnt;
    logic [2*W-1:0] prod;
    logic           n_bad;

    always_comb begin
        prod  = (2*W)'(acc) * (2*W)'(cnt);
        n_bad = n_reg[W-1] || ($signed(n_reg) > N_MAX_S);
    end

    // d_out/ovrflow are loaded on the transition into DONE so they are
    // already stable during the single valid_out cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            valid_out <= 1'b0;
            ovrflow   <= 1'b0;
            d_out     <= '0;
            n_reg     <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        n_reg <= n;
                        acc   <= W'(1);
                        cnt   <= W'(2);
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (n_bad) begin
                        d_out     <= '1;
                        ovrflow   <= 1'b1;
                        valid_out <= 1'b1;
                        state     <= DONE;
                    end else if (n_reg <= W'(1)) begin
                        d_out     <= acc;
                        ovrflow   <= 1'b0;
                        valid_out <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= MUL;
                    end
                end
                MUL: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (prod > MAX_P) begin
                        // unreachable with the default parameters, kept for other limits
                        d_out     <= '1;
                        ovrflow   <= 1'b1;
                        valid_out <= 1'b1;
                        state     <= DONE;
                    end else begin
                        acc <= prod[W-1:0];
                        if (cnt == n_reg) begin
                            d_out     <= prod[W-1:0];
                            ovrflow   <= 1'b0;
                            valid_out <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cnt <= cnt + W'(1);
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fact_seq_ctrl.sv
// Bench for fact_seq_ctrl: directed spec scenarios plus random requests against a
// plain-arithmetic factorial/latency model.
module tb_fact_seq_ctrl;
    localparam int W = 28;
    localparam int N_MAX = 11;
    localparam longint MAX_RESULT = 99_999_999;
    localparam int WIN = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         valid_in = 1'b0;
    logic [W-1:0] n = '0;
    logic         cancel = 1'b0;
    logic         busy, valid_out, ovrflow;
    logic [W-1:0] d_out;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] last_d = '0;
    logic         last_o = 1'b0;

    fact_seq_ctrl #(.W(W), .N_MAX(N_MAX), .MAX_RESULT(99_999_999)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .n(n), .cancel(cancel),
        .busy(busy), .valid_out(valid_out), .ovrflow(ovrflow), .d_out(d_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: factorial with range check; latency in cycles after the accept edge.
    task automatic model(input logic [W-1:0] nv, output logic [W-1:0] d, output logic o,
                         output int lat);
        longint sn, p;
        sn = longint'($signed(nv));
        o = 1'b0;
        p = 1;
        if (sn < 0 || sn > N_MAX) begin
            o = 1'b1;
            lat = 2;
        end else begin
            for (longint k = 2; k <= sn; k++) begin
                p = p * k;
                if (p > MAX_RESULT) o = 1'b1;
            end
            lat = (sn >= 2) ? int'(sn) + 1 : 2;
        end
        d = o ? '1 : W'(p);
    endtask

    // Issue one request, optionally cancel at cycle cancel_at and strobe valid_in
    // (n=4) in cycles spam_lo..spam_hi while busy; then observe WIN cycles.
    task automatic run_req(input string tag, input logic [W-1:0] nv, input int cancel_at,
                           input int spam_lo, input int spam_hi);
        logic [W-1:0] ed, dv;
        logic eo, ov;
        int lat, first_v, v_cnt, busy_bad;
        bit cancelled, exp_busy;
        model(nv, ed, eo, lat);
        cancelled = (cancel_at > 0) && (cancel_at < lat);
        first_v = 0; v_cnt = 0; busy_bad = 0; dv = '0; ov = 1'b0;
        @(negedge clk);
        valid_in = 1'b1;
        n = nv;
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clk);
            exp_busy = cancelled ? (k <= cancel_at) : (k <= lat);
            if (busy !== exp_busy) busy_bad++;
            if (valid_out === 1'b1) begin
                v_cnt++;
                if (first_v == 0) begin
                    first_v = k;
                    dv = d_out;
                    ov = ovrflow;
                end
            end
            valid_in = (k >= spam_lo) && (k <= spam_hi);
            if (valid_in) n = W'(4);
            cancel = (k == cancel_at);
        end
        valid_in = 1'b0;
        cancel = 1'b0;
        chk({tag, " busy"}, 64'(busy_bad), 64'd0);
        if (cancelled) begin
            chk({tag, " no_valid"}, 64'(v_cnt), 64'd0);
            chk({tag, " d_held"}, 64'(d_out), 64'(last_d));
            chk({tag, " ovf_held"}, 64'(ovrflow), 64'(last_o));
        end else begin
            chk({tag, " valid_cnt"}, 64'(v_cnt), 64'd1);
            chk({tag, " latency"}, 64'(first_v), 64'(lat));
            chk({tag, " d_out"}, 64'(dv), 64'(ed));
            chk({tag, " ovrflow"}, 64'(ov), 64'(eo));
            chk({tag, " d_hold"}, 64'(d_out), 64'(ed));
            last_d = ed;
            last_o = eo;
        end
    endtask

    initial begin
        int vcount;
        logic [W-1:0] rn;
        int ca;
        // reset state
        #12;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst valid", 64'(valid_out), 64'd0);
        chk("rst ovf", 64'(ovrflow), 64'd0);
        chk("rst d_out", 64'(d_out), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_req("n5", W'(5), 0, 0, 0);
        chk("n5 value", 64'(last_d), 64'd120);
        run_req("n0", W'(0), 0, 0, 0);
        run_req("n1", W'(1), 0, 0, 0);
        run_req("n11", W'(11), 0, 0, 0);
        chk("n11 value", 64'(last_d), 64'd39_916_800);
        run_req("n12", W'(12), 0, 0, 0);
        run_req("nneg3", 28'hFFFFFFD, 0, 0, 0);
        chk("nneg3 value", 64'(last_d), 64'hFFFFFFF);
        run_req("cancel9", W'(9), 4, 0, 0);
        run_req("n3", W'(3), 0, 0, 0);
        chk("n3 value", 64'(last_d), 64'd6);
        run_req("cancel_chk", W'(6), 1, 0, 0);
        run_req("cancel_done", W'(4), 5, 0, 0);
        run_req("spam7", W'(7), 0, 2, 8);
        chk("spam7 value", 64'(last_d), 64'd5040);

        // async reset mid-operation
        @(negedge clk);
        valid_in = 1'b1;
        n = W'(10);
        @(negedge clk);
        valid_in = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst busy", 64'(busy), 64'd0);
        chk("arst valid", 64'(valid_out), 64'd0);
        chk("arst ovf", 64'(ovrflow), 64'd0);
        chk("arst d_out", 64'(d_out), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        vcount = 0;
        for (int k = 0; k < WIN; k++) begin
            @(negedge clk);
            if (valid_out === 1'b1 || busy === 1'b1) vcount++;
        end
        chk("arst quiet", 64'(vcount), 64'd0);
        last_d = '0;
        last_o = 1'b0;

        // random requests, some out of range, some cancelled
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: rn = W'($urandom);
                1: rn = W'(-int'($urandom_range(1, 5)));
                default: rn = W'($urandom_range(0, 13));
            endcase
            ca = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
            run_req($sformatf("rnd%0d", i), rn, ca, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
